// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder (package)
//  Description : Shared definitions for the bit-serial adder: default operand
//                width and the FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder;

    // Default operand width when the instantiating code does not override it.
    localparam int unsigned C_WIDTH_DEFAULT = 8;

    // FSM state encoding, kept as plain constants for legacy tool flows.
    typedef logic [1:0] state_t;

    localparam state_t C_ST_IDLE = 2'd0;
    localparam state_t C_ST_RUN  = 2'd1;
    localparam state_t C_ST_DONE = 2'd2;

endpackage : adder
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : One-bit full adder cell used as the per-bit datapath of the
//                serial adder.
//  Ports       : a, b  - operand bits
//                c     - carry in
//                sum   - sum bit
//                carry - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial unsigned adder. Operands are accepted with a
//                valid/ready handshake, summed LSB first through a single
//                full_adder cell (one bit per clock), and the result is held
//                until the consumer takes it.
//  Ports       : clk, rst            - clock, asynchronous active-high reset
//                in_valid / in_ready - operand handshake
//                a, b, cin           - operands and carry-in
//                out_valid/out_ready - result handshake
//                sum, cout           - result modulo 2^WIDTH and carry out
//                ovf                 - signed overflow (SERIAL_ADDER_OVF_EN only)
//  Config      : `define SERIAL_ADDER_OVF_EN adds the ovf output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import adder::*;
#(
    parameter int WIDTH = C_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int             CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             w_fa_sum;
    logic             w_fa_carry;

    full_adder u_full_adder (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (carry_q),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            C_ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    res_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = C_ST_RUN;
                end
            end
            C_ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                // After WIDTH shifts the first sum bit lands in bit 0.
                res_d   = {w_fa_sum, res_q[WIDTH-1:1]};
                carry_d = w_fa_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
`ifdef SERIAL_ADDER_OVF_EN
                    // On the MSB, carry_q is the carry into the MSB.
                    ovf_d   = carry_q ^ w_fa_carry;
`endif
                    state_d = C_ST_DONE;
                end
            end
            C_ST_DONE: begin
                if (out_ready) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= C_ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Handshake flags decode straight from state so reset takes effect at once.
    assign in_ready  = (state_q == C_ST_IDLE);
    assign out_valid = (state_q == C_ST_DONE);
    assign sum       = res_q;
    // The carry register still holds the MSB carry-out while in DONE.
    assign cout      = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule : serial_adder
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning operands are offered.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-007 SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-008 SHALL have port cin, input, 1 bit: carry-in for the LSB.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning a result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-011 SHALL have port sum, output, WIDTH bits: the result of a+b+cin, modulo 2^WIDTH.
REQ-012 SHALL have port cout, output, 1 bit: the carry out of the MSB.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL, on an in_valid&&in_ready edge, capture a, b and cin into shift/carry registers, clear the bit counter and go to RUN.
REQ-016 SHALL, in RUN, process one bit per cycle, LSB first, through one full_adder cell:
- cell inputs are shift-register LSBs plus the carry register;
- the sum bit is shifted into the result MSB;
- the carry register is loaded with the cell carry.
REQ-017 SHALL go to DONE on the edge that processes bit WIDTH-1; out_valid is high exactly WIDTH cycles after the accept edge.
REQ-018 SHALL hold sum and cout stable in DONE until out_valid&&out_ready, then return to IDLE.
REQ-019 SHALL NOT accept new operands in the DONE cycle; in_ready rises the cycle after the output handshake.
REQ-020 SHALL ignore a, b, cin and in_valid while in RUN or DONE.
REQ-021 SHALL produce wrap-around results: all-ones+1 gives sum=0, cout=1.

Reset
REQ-022 SHALL, on rst high, immediately force IDLE with in_ready=1, out_valid=0, sum=0, cout=0, counter=0 and the carry register cleared.
REQ-023 SHALL, when rst is asserted mid-RUN or mid-DONE, discard the operation with no output handshake; the first accept after release behaves as from power-up.

Configuration
REQ-024 SHALL honour macro SERIAL_ADDER_OVF_EN:
- When defined: adds output port ovf (1 bit), the signed two's-complement overflow flag, equal to (carry into MSB) XOR cout. It is valid with out_valid and is 0 in reset.
- When undefined: no ovf port and no extra logic.

Structure
REQ-025 SHALL place the FSM state typedef and the default WIDTH constant in shared package adder.
REQ-026 SHALL instantiate existing module full_adder (ports a, b, c, sum, carry) as the single per-bit cell sub-module; no other sub-modules.

Verification (WIDTH=8)
REQ-027 SHALL cover: a=3, b=5, cin=0 accepted -> out_valid after 8 cycles, sum=8, cout=0.
REQ-028 SHALL cover: a=255, b=1, cin=0 -> sum=0, cout=1; then a=0, b=0, cin=1 -> sum=1, cout=0.
REQ-029 SHALL cover: out_ready held low 5 cycles in DONE -> sum/cout stable, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-030 SHALL cover: rst pulsed at RUN bit 4 -> in_ready=1 and out_valid=0 immediately; next a=10, b=20 gives sum=30.
REQ-031 SHALL cover: a/b changed every cycle during RUN with in_valid=1 -> result matches the captured operands only.
REQ-032 SHALL cover, with SERIAL_ADDER_OVF_EN: a=127, b=1 -> sum=128, cout=0, ovf=1; a=255, b=1 -> ovf=0.
